// File: rtl/mbinit_pkg.sv
// Shared MBINIT message definitions.
// Holds the idle-code constant, the message-code enum and the watchdog
// state type used by the receive-side capture logic. No ports.
package mbinit_pkg;

  localparam int MSG_W = 4;

  localparam logic [MSG_W-1:0] IDLE_CODE = '0;

  typedef enum logic [MSG_W-1:0] {
    MSG_IDLE = 4'h0,
    MSG_MAX  = 4'hF
  } msg_code_e;

  typedef enum logic [1:0] {
    WD_IDLE    = 2'd0,
    WD_ARMED   = 2'd1,
    WD_EXPIRED = 2'd2
  } wd_state_e;

endpackage

// File: rtl/delayed_msg_fifo.sv
// First-word-fall-through synchronous FIFO for captured message codes.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   i_push     write request (i_data)
//   i_pop      read request; ignored when empty
//   o_data     head entry, 0 when empty
//   o_valid    FIFO non-empty
//   o_drop     push requested but refused (full with no pop this cycle)
//   o_level    current occupancy
module delayed_msg_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_valid,
  output logic                     o_drop,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  // Extra wrap bit distinguishes full from empty when the low bits match.
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop   = i_pop && !w_empty;
  // A simultaneous pop frees a slot, so a push into a full FIFO still lands.
  assign w_push  = i_push && (!w_full || w_pop);
  assign o_drop  = i_push && !w_push;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

  assign o_data  = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
  assign o_valid = !w_empty;
  assign o_level = r_wr_ptr - r_rd_ptr;

endmodule

// File: rtl/delayed_msg_capture.sv
// Receive-side capture of delayed MBINIT message codes.
// Detects each new non-idle code once, buffers it in a FWFT FIFO drained
// over valid/ready, and runs an arm-able no-message watchdog.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   in_signal    delayed message code, 0 = idle
//   out_msg      FIFO head code, 0 when empty
//   out_valid    FIFO non-empty
//   out_ready    consumer takes the head this cycle
//   timeout_arm  pulse: start/restart the watchdog
//   timeout      sticky watchdog expiry flag
//   overflow     sticky: a new code was dropped on a full FIFO
//   level        FIFO occupancy
module delayed_msg_capture
  import mbinit_pkg::*;
#(
  parameter int SIGNAL_WIDTH   = 4,
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 8000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [SIGNAL_WIDTH-1:0]   in_signal,
  output logic [SIGNAL_WIDTH-1:0]   out_msg,
  output logic                      out_valid,
  input  logic                      out_ready,
  input  logic                      timeout_arm,
  output logic                      timeout,
  output logic                      overflow,
  output logic [$clog2(DEPTH):0]    level
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);

  logic [SIGNAL_WIDTH-1:0] r_prev_code;
  logic                    r_overflow;
  wd_state_e               r_wd_state;
  logic [CW-1:0]           r_wd_cnt;
  logic                    r_timeout;

  wd_state_e               w_wd_state_nxt;
  logic [CW-1:0]           w_wd_cnt_nxt;
  logic                    w_timeout_nxt;
  logic                    w_new_msg;
  logic                    w_drop;

  assign w_new_msg = (in_signal != SIGNAL_WIDTH'(IDLE_CODE)) &&
                     (in_signal != r_prev_code);

  delayed_msg_fifo #(
    .WIDTH (SIGNAL_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_new_msg),
    .i_data  (in_signal),
    .i_pop   (out_ready),
    .o_data  (out_msg),
    .o_valid (out_valid),
    .o_drop  (w_drop),
    .o_level (level)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev_code <= '0;
      r_overflow  <= 1'b0;
      r_wd_state  <= WD_IDLE;
      r_wd_cnt    <= '0;
      r_timeout   <= 1'b0;
    end else begin
      r_prev_code <= in_signal;
      if (w_drop) r_overflow <= 1'b1;
      r_wd_state  <= w_wd_state_nxt;
      r_wd_cnt    <= w_wd_cnt_nxt;
      r_timeout   <= w_timeout_nxt;
    end
  end

  // Arm beats capture; capture beats expiry on the final counting cycle.
  always_comb begin
    w_wd_state_nxt = r_wd_state;
    w_wd_cnt_nxt   = r_wd_cnt;
    w_timeout_nxt  = r_timeout;
    case (r_wd_state)
      WD_IDLE: begin
        w_wd_cnt_nxt  = '0;
        w_timeout_nxt = 1'b0;
        if (timeout_arm) w_wd_state_nxt = WD_ARMED;
      end
      WD_ARMED: begin
        if (timeout_arm) begin
          w_wd_cnt_nxt = '0;
        end else if (w_new_msg) begin
          w_wd_state_nxt = WD_IDLE;
          w_wd_cnt_nxt   = '0;
        end else if (r_wd_cnt == CW'(TIMEOUT_CYCLES - 2)) begin
          w_wd_state_nxt = WD_EXPIRED;
          w_wd_cnt_nxt   = r_wd_cnt + 1'b1;
          w_timeout_nxt  = 1'b1;
        end else begin
          w_wd_cnt_nxt = r_wd_cnt + 1'b1;
        end
      end
      WD_EXPIRED: begin
        w_timeout_nxt = 1'b1;
        if (timeout_arm) begin
          w_wd_state_nxt = WD_ARMED;
          w_wd_cnt_nxt   = '0;
          w_timeout_nxt  = 1'b0;
        end
      end
      default: begin
        w_wd_state_nxt = WD_IDLE;
        w_wd_cnt_nxt   = '0;
        w_timeout_nxt  = 1'b0;
      end
    endcase
  end

  assign timeout  = r_timeout;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_delayed_msg_capture.sv
module tb_delayed_msg_capture;

  localparam int SW    = 4;
  localparam int DEPTH = 4;
  localparam int T     = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic [SW-1:0] in_signal;
  logic [SW-1:0] out_msg;
  logic          out_valid;
  logic          out_ready;
  logic          timeout_arm;
  logic          timeout;
  logic          overflow;
  logic [$clog2(DEPTH):0] level;

  always #5 clk = ~clk;

  delayed_msg_capture #(
    .SIGNAL_WIDTH   (SW),
    .DEPTH          (DEPTH),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_signal   (in_signal),
    .out_msg     (out_msg),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .timeout_arm (timeout_arm),
    .timeout     (timeout),
    .overflow    (overflow),
    .level       (level)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: a queue of buffered codes plus a watchdog deadline
  // expressed as an absolute edge number (-1 when not armed).
  logic [SW-1:0] mq[$];
  logic [SW-1:0] m_prev     = '0;
  bit            m_ovf      = 1'b0;
  bit            m_to       = 1'b0;
  int            m_deadline = -1;
  int            edge_n     = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, obs, exp, edge_n);
    end
  endtask

  task automatic model_update(input logic [SW-1:0] sig, input bit rdy, input bit arm, input bit rs);
    bit is_new;
    if (rs) begin
      mq.delete();
      m_prev     = '0;
      m_ovf      = 1'b0;
      m_to       = 1'b0;
      m_deadline = -1;
      return;
    end
    is_new = (sig != 0) && (sig != m_prev);
    if (rdy && mq.size() > 0) void'(mq.pop_front());
    if (is_new) begin
      if (mq.size() < DEPTH) mq.push_back(sig);
      else m_ovf = 1'b1;
    end
    m_prev = sig;
    if (arm) begin
      m_deadline = edge_n + T - 1;
      m_to       = 1'b0;
    end else if (m_deadline >= 0 && is_new) begin
      m_deadline = -1;
    end else if (m_deadline >= 0 && edge_n == m_deadline) begin
      m_to       = 1'b1;
      m_deadline = -1;
    end
  endtask

  task automatic check_outputs();
    chk("out_valid", out_valid, (mq.size() > 0) ? 1 : 0);
    chk("out_msg",   out_msg,   (mq.size() > 0) ? mq[0] : 0);
    chk("level",     level,     mq.size());
    chk("timeout",   timeout,   m_to);
    chk("overflow",  overflow,  m_ovf);
  endtask

  task automatic step(input logic [SW-1:0] sig, input bit rdy, input bit arm, input bit rs);
    in_signal   = sig;
    out_ready   = rdy;
    timeout_arm = arm;
    rst         = rs;
    @(posedge clk);
    edge_n++;
    model_update(sig, rdy, arm, rs);
    #1;
    check_outputs();
  endtask

  logic [SW-1:0] cur_sig;

  initial begin
    in_signal = '0; out_ready = 1'b0; timeout_arm = 1'b0; rst = 1'b1;

    // reset state
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    chk("rst_valid", out_valid, 0);
    chk("rst_level", level, 0);

    // held code counts once
    step(3, 0, 0, 0);
    chk("hold_first_msg", out_msg, 3);
    for (int i = 0; i < 4; i++) step(3, 0, 0, 0);
    chk("hold_level", level, 1);
    step(0, 1, 0, 0);
    chk("hold_drained", out_valid, 0);

    // 3,5,0,5 -> 3,5,5
    step(3, 0, 0, 0); step(5, 0, 0, 0); step(0, 0, 0, 0); step(5, 0, 0, 0);
    chk("seq_level", level, 3);
    chk("seq_head0", out_msg, 3);
    step(0, 1, 0, 0); chk("seq_head1", out_msg, 5);
    step(0, 1, 0, 0); chk("seq_head2", out_msg, 5);
    step(0, 1, 0, 0);
    chk("seq_empty_valid", out_valid, 0);
    chk("seq_empty_msg", out_msg, 0);

    // overflow, then push-while-full with pop
    step(0, 0, 0, 1);
    for (int c = 1; c <= 6; c++) step(SW'(c), 0, 0, 0);
    chk("ovf_level", level, 4);
    chk("ovf_flag", overflow, 1);
    chk("ovf_head", out_msg, 1);
    step(7, 1, 0, 0);
    chk("full_pop_push_level", level, 4);
    chk("full_pop_push_head", out_msg, 2);

    // watchdog expiry and re-arm
    step(0, 0, 0, 1);
    step(0, 0, 1, 0);
    for (int i = 0; i < T - 2; i++) step(0, 0, 0, 0);
    chk("wd_not_yet", timeout, 0);
    step(0, 0, 0, 0);
    chk("wd_expired", timeout, 1);
    step(6, 0, 0, 0);
    chk("wd_sticky_after_capture", timeout, 1);
    step(0, 0, 1, 0);
    chk("wd_rearm_clears", timeout, 0);

    // capture cancels; arm + new code same cycle restarts
    step(0, 0, 0, 1);
    step(0, 0, 1, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
    step(6, 0, 0, 0);
    for (int i = 0; i < 12; i++) step(0, 0, 0, 0);
    chk("wd_cancelled", timeout, 0);
    step(9, 0, 1, 0);
    for (int i = 0; i < T - 2; i++) step(0, 0, 0, 0);
    chk("wd_arm_wins_pending", timeout, 0);
    step(0, 0, 0, 0);
    chk("wd_arm_wins_fire", timeout, 1);

    // reset with buffered data, timeout and overflow set
    step(0, 0, 0, 1);
    for (int c = 1; c <= 5; c++) step(SW'(c), 0, 0, 0);
    step(0, 1, 1, 0);
    for (int i = 0; i < T - 1; i++) step(0, 0, 0, 0);
    chk("pre_rst_level", level, 3);
    chk("pre_rst_timeout", timeout, 1);
    chk("pre_rst_overflow", overflow, 1);
    step(7, 0, 0, 1);
    chk("rst_clears_valid", out_valid, 0);
    chk("rst_clears_timeout", timeout, 0);
    chk("rst_clears_overflow", overflow, 0);
    for (int i = 0; i < 3; i++) step(7, 0, 0, 0);
    chk("held_through_rst_level", level, 1);
    chk("held_through_rst_msg", out_msg, 7);

    // randomized phase
    cur_sig = '0;
    for (int i = 0; i < 3000; i++) begin
      bit rdy;
      bit arm;
      bit rs;
      if (i < 1500) begin
        cur_sig = SW'($urandom_range(0, 4));
        rdy     = ($urandom_range(0, 3) == 0);
      end else begin
        if ($urandom_range(0, 14) == 0) cur_sig = SW'($urandom_range(0, 15));
        rdy = ($urandom_range(0, 2) != 0);
      end
      arm = ($urandom_range(0, 25) == 0);
      rs  = ($urandom_range(0, 400) == 0);
      step(cur_sig, rdy, arm, rs);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
